sequence_controller: RTL and testbench
======================================

# sequence_controller

Eight-phase instruction sequencer for the 8-bit RISC CPU. It steps through fetch and execute phases and decodes the current 3-bit opcode into the datapath controls. These controls include `sel` for the address mux, which picks the PC address when `sel`=1 and the IR operand address when `sel`=0. They also cover memory `rd`/`wr`, the IR, AC and PC load and increment strobes, and the data bus driver enable. It also latches the HLT condition and freezes the CPU until reset.

## Interface
- No parameters. Phase count (8), opcode width (3) and encoding are fixed.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 3: opcode field from the instruction register (IR); valid from phase 3 onward.
- `zero` input 1: accumulator-zero flag from the ALU.
- `sel` output 1: address mux select; 1 = PC address, 0 = IR operand address.
- `rd` output 1: memory read enable.
- `ld_ir` output 1: load instruction register.
- `halt` output 1: CPU halted indication.
- `inc_pc` output 1: increment program counter.
- `ld_ac` output 1: load accumulator.
- `ld_pc` output 1: load program counter from IR address.
- `wr` output 1: memory write strobe.
- `data_e` output 1: drive AC onto the data bus.
- `phase` output 3: current phase number, for debug and verification.

## Operation
- State consists of a 3-bit phase counter (0..7) and a 1-bit `halted` flag.
- The phase counter increments every cycle and wraps from 7 to 0 unless `halted` is set.
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD, AND, XOR or LDA.
- Outputs are combinational decodes of (phase, opcode, zero, halted) and are glitch-tolerant.
- Any output not listed for a phase is 0.
- Phase 0 INST_ADDR: `sel`.
- Phase 1 INST_FETCH: `sel`, `rd`.
- Phase 2 INST_LOAD: `sel`, `rd`, `ld_ir`.
- Phase 3 IDLE: `sel`, `rd`, `ld_ir`.
- Phase 4 OP_ADDR: `inc_pc`; `halt` = (opcode==HLT).
- Phase 5 OP_FETCH: `rd` = ALUOP.
- Phase 6 ALU_OP: `rd` = ALUOP; `inc_pc` = (opcode==SKZ && zero); `ld_pc` = (opcode==JMP); `data_e` = (opcode==STO).
- Phase 7 STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `ld_pc` = (opcode==JMP); `wr` = (opcode==STO); `data_e` = (opcode==STO).
- Halt entry: `halted` is set on the rising edge that ends phase 4 when opcode==HLT. The phase counter then holds at 5.
- While `halted`=1: `halt`=1 and every other control output is 0, regardless of opcode or zero. `phase` reads 5.
- `halted` is cleared only by `rst`.

## Timing
- Reset values (while `rst`=1 and immediately after): phase=0, halted=0, `sel`=1, all other controls 0, `halt`=0.
- `rst` asserted mid-instruction, including mid-STORE and while halted, forces phase 0 asynchronously. Any pending `wr` drops in the same delta.
- On the first rising edge after `rst` deasserts, phase moves 0→1.
- One instruction takes exactly 8 cycles. The next instruction's INST_ADDR follows phase 7 with no gap.
- `inc_pc` is high for exactly one cycle in phase 4 of every instruction, including HLT. This gives PC+1 before halt takes effect.
- The SKZ second increment in phase 6 depends on `zero` sampled in that same cycle, so a skipped instruction yields PC+2 total.
- For JMP, `ld_pc` spans phases 6–7 (2 cycles). `inc_pc` in phase 4 is overridden by the later load.
- For STO, `data_e` spans phases 6–7 and `wr` is only in phase 7, so data is stable one cycle before the write.
- `opcode` changes that occur during phases 0–2 have no effect on phase 0–2 outputs.

## Test plan
- Reset: hold `rst`=1 for 3 clk, toggling `opcode`. Required: `phase`=0, `sel`=1, all others 0. After release, `phase` reads 1,2,…,7,0 on successive edges.
- ADD (opcode=2), zero=0, one full instruction. Required: `rd`=1 in phases 1,2,3,5,6,7; `ld_ir`=1 in phases 2–3; `inc_pc` only in phase 4; `ld_ac` only in phase 7; `sel`=0 in phases 4–7.
- SKZ (opcode=1): with zero=1, `inc_pc` is high in phases 4 and 6 (2 pulses). With zero=0, only phase 4 (1 pulse). `rd`=0 in phases 5–7.
- STO (opcode=6): `data_e`=1 in phases 6–7, `wr`=1 only in phase 7, `rd`=0 and `ld_ac`=0 in phases 5–7. JMP (opcode=7): `ld_pc`=1 in phases 6–7, `wr`=0.
- HLT (opcode=0): `halt`=1 in phase 4, then `phase` is stuck at 5 with `halt`=1 and all else 0 for 20 cycles. Next apply `rst` pulse mid-cycle: `halt` drops immediately and sequencing resumes from phase 0.
- Async reset during phase 7 of STO: `wr` and `data_e` fall in the same timestep as `rst` rises, with no clock edge needed.

Source files
------------

// File: rtl/sequence_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit RISC CPU.
// Decodes phase, opcode and zero flag into datapath control strobes.
module sequence_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic [2:0] phase
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic [2:0] r_phase;
    logic       r_halted;
    logic [2:0] w_phase_nxt;
    logic       w_halted_nxt;
    logic       w_aluop;

    assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
    assign phase   = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= 3'd0;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // HLT is taken at the end of phase 4, so the counter parks at 5
    always_comb begin
        w_phase_nxt  = r_phase + 3'd1;
        w_halted_nxt = r_halted;
        if (r_halted) begin
            w_phase_nxt = r_phase;
        end else if (r_phase == 3'd4 && opcode == OP_HLT) begin
            w_halted_nxt = 1'b1;
            w_phase_nxt  = 3'd5;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            unique case (r_phase)
                3'd0: sel = 1'b1;
                3'd1: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                3'd2, 3'd3: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                3'd4: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                3'd5: rd = w_aluop;
                3'd6: begin
                    rd     = w_aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                3'd7: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_controller.sv
// Scoreboard bench for sequence_controller: driver queues expected
// {phase, controls}; monitor pops and compares at each sample point.
`timescale 1ns/1ps
module tb_sequence_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];
    event        mon_ev;

    sequence_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // Bit order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
    function automatic logic [8:0] exp_ctrl(input logic [2:0] op,
                                            input logic z, input int p);
        logic [8:0] c;
        c = 9'b0;
        case (p)
            0: c = 9'b100000000;
            1: c = 9'b110000000;
            2, 3: c = 9'b111000000;
            4: c = (op == 3'd0) ? 9'b000110000 : 9'b000010000;
            default: begin
                case (op)
                    3'd1: c = (p == 6 && z) ? 9'b000010000 : 9'b0;
                    3'd2, 3'd3, 3'd4, 3'd5:
                        c = (p == 7) ? 9'b010001000 : 9'b010000000;
                    3'd6: c = (p == 6) ? 9'b000000001 :
                              (p == 7) ? 9'b000000011 : 9'b0;
                    3'd7: c = (p >= 6) ? 9'b000000100 : 9'b0;
                    default: c = 9'b0;
                endcase
            end
        endcase
        return c;
    endfunction

    task automatic step(input logic r, input logic [2:0] op,
                        input logic z, input logic [2:0] ph,
                        input logic [8:0] c);
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
        zero   = z;
        exp_q.push_back({ph, c});
    endtask

    // Junk opcode in phases 0-2 must not disturb fetch outputs
    task automatic instr(input logic [2:0] op, input logic z,
                         input int last);
        for (int p = 0; p <= last; p++)
            step(1'b0, (p < 3) ? (op ^ 3'd5) : op, z, 3'(p),
                 exp_ctrl(op, z, p));
    endtask

    task automatic async_check;
        #1;
        exp_q.push_back({3'd0, 9'b100000000});
        ->mon_ev;
    endtask

    initial begin
        logic [11:0] e;
        logic [11:0] got;
        forever begin
            @(negedge clk or mon_ev);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {phase, sel, rd, ld_ir, halt, inc_pc,
                       ld_ac, ld_pc, wr, data_e};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL chk%0d t=%0t got ph=%0d ctl=%b exp ph=%0d ctl=%b",
                             checks, $time, got[11:9], got[8:0],
                             e[11:9], e[8:0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'(i * 3 + 1), 1'b1, 3'd0, 9'b100000000);

        instr(3'd2, 1'b0, 7);
        instr(3'd1, 1'b1, 7);
        instr(3'd1, 1'b0, 7);
        instr(3'd3, 1'b1, 7);
        instr(3'd4, 1'b0, 7);
        instr(3'd5, 1'b1, 7);
        instr(3'd6, 1'b0, 7);
        instr(3'd7, 1'b1, 7);
        instr(3'd0, 1'b0, 4);
        for (int i = 0; i < 20; i++)
            step(1'b0, 3'(i), 1'(i), 3'd5, 9'b000100000);

        @(posedge clk);
        #3;
        rst = 1'b1;
        async_check();

        instr(3'd6, 1'b1, 7);
        #5;
        rst = 1'b1;
        async_check();

        instr(3'd2, 1'b1, 7);
        step(1'b0, 3'd7, 1'b0, 3'd0, 9'b100000000);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
